// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16-entry show-ahead RX FIFO with trigger level, sticky overrun and optional char timeout (UART_RX_FIFO_TIMEOUT_EN)
module uart_rx_fifo #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 208320
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flag,
    input  logic              i_rd_en,
    input  logic              i_fifo_clr,
    input  logic              i_ovr_clr,
    input  logic [1:0]        i_trig_lvl,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [4:0]        o_count,
    output logic              o_trig,
    output logic              o_overrun,
    output logic              o_timeout
);
    logic [DATA_W-1:0] mem [16];
    logic [3:0]        wr_ptr, rd_ptr;
    logic [4:0]        count, thr;
    logic              do_push, do_pop, ovr_set;

    always_comb begin
        do_pop  = i_rd_en && count != 5'd0;
        do_push = i_flag && (count != 5'd16 || do_pop);
        ovr_set = i_flag && count == 5'd16 && !do_pop;
        thr     = i_trig_lvl == 2'd0 ? 5'd1 :
                  i_trig_lvl == 2'd1 ? 5'd4 :
                  i_trig_lvl == 2'd2 ? 5'd8 : 5'd14;
    end

    assign o_rd_data = mem[rd_ptr];
    assign o_empty   = count == 5'd0;
    assign o_full    = count == 5'd16;
    assign o_count   = count;
    assign o_trig    = count >= thr;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 4'd1;
            count <= count + {4'b0, do_push} - {4'b0, do_pop};
        end
    end

    // a lost byte wins over a simultaneous clear so the host never misses it
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) o_overrun <= 1'b0;
        else              o_overrun <= ovr_set ? 1'b1 : i_ovr_clr ? 1'b0 : o_overrun;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [19:0] idle_cnt;
    logic        idle, hit;

    always_comb begin
        idle = count != 5'd0 && !do_push && !do_pop && !i_fifo_clr;
        hit  = idle_cnt + 20'd1 == 20'(TIMEOUT_CYCLES);
    end

    // counter saturates at the limit so a long idle never wraps back
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            idle_cnt  <= !idle ? 20'd0 : idle_cnt == 20'(TIMEOUT_CYCLES) ? idle_cnt : idle_cnt + 20'd1;
            o_timeout <= idle && (o_timeout || hit);
        end
    end
`else
    assign o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_flag = 1'b0, i_rd_en = 1'b0, i_fifo_clr = 1'b0, i_ovr_clr = 1'b0;
    logic [1:0] i_trig_lvl = 2'd0;
    logic [7:0] o_rd_data;
    logic       o_empty, o_full, o_trig, o_overrun, o_timeout;
    logic [4:0] o_count;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .TIMEOUT_CYCLES(100)) dut (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_data(i_data), .i_flag(i_flag),
        .i_rd_en(i_rd_en), .i_fifo_clr(i_fifo_clr), .i_ovr_clr(i_ovr_clr),
        .i_trig_lvl(i_trig_lvl), .o_rd_data(o_rd_data), .o_empty(o_empty),
        .o_full(o_full), .o_count(o_count), .o_trig(o_trig),
        .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic flag, input logic [7:0] d, input logic rd);
        i_flag  = flag;
        i_data  = d;
        i_rd_en = rd;
        step();
        i_flag  = 1'b0;
        i_rd_en = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_count", o_count, 0);
        chk("rst_trig", o_trig, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_to", o_timeout, 0);
        chk("rst_data", o_rd_data, 0);
        #4 rst_n = 1'b1;
        step();

        cyc(1, 8'h5A, 0);
        chk("single_empty", o_empty, 0);
        chk("single_count", o_count, 1);
        chk("single_data", o_rd_data, 8'h5A);
        chk("single_trig", o_trig, 1);
        cyc(0, 0, 1);
        chk("single_pop_empty", o_empty, 1);
        chk("single_pop_trig", o_trig, 0);

        cyc(0, 0, 1);
        chk("pop_empty_count", o_count, 0);
        cyc(1, 8'h3C, 1);
        chk("empty_pushpop_count", o_count, 1);
        chk("empty_pushpop_data", o_rd_data, 8'h3C);
        cyc(0, 0, 1);

        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        chk("fill_full", o_full, 1);
        chk("fill_count", o_count, 16);
        chk("fill_ovr0", o_overrun, 0);
        cyc(1, 8'hAA, 0);
        chk("ovr_set", o_overrun, 1);
        chk("ovr_count", o_count, 16);
        chk("ovr_head", o_rd_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", o_rd_data, 32'(i));
            cyc(0, 0, 1);
        end
        chk("drain_empty", o_empty, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h10 + i), 0);
        chk("wrap_count", o_count, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_data", o_rd_data, 32'(8'h10 + i));
            cyc(0, 0, 1);
        end
        chk("wrap_empty", o_empty, 1);

        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0);
        chk("flush_pre_count", o_count, 5);
        i_fifo_clr = 1'b1;
        step();
        i_fifo_clr = 1'b0;
        chk("flush_count", o_count, 0);
        chk("flush_empty", o_empty, 1);
        chk("flush_ovr_kept", o_overrun, 1);
        i_ovr_clr = 1'b1;
        step();
        i_ovr_clr = 1'b0;
        chk("ovr_clr", o_overrun, 0);

        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
        cyc(1, 8'h77, 1);
        chk("fullpp_ovr", o_overrun, 0);
        chk("fullpp_count", o_count, 16);
        chk("fullpp_head", o_rd_data, 8'h21);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1);
        chk("fullpp_tail", o_rd_data, 8'h77);
        chk("fullpp_tail_count", o_count, 1);
        cyc(0, 0, 1);
        chk("fullpp_empty", o_empty, 1);

        i_trig_lvl = 2'd2;
        for (int i = 0; i < 7; i++) cyc(1, 8'(i), 0);
        chk("trig8_at7", o_trig, 0);
        cyc(1, 8'h07, 0);
        chk("trig8_at8", o_trig, 1);
        i_trig_lvl = 2'd3;
        #1;
        chk("trig14_at8", o_trig, 0);
        i_trig_lvl = 2'd2;
        #1;
        chk("trig8_back", o_trig, 1);
        cyc(0, 0, 1);
        chk("trig8_pop7", o_trig, 0);
        i_fifo_clr = 1'b1;
        step();
        i_fifo_clr = 1'b0;
        i_trig_lvl = 2'd0;

        cyc(1, 8'hC3, 0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        for (int i = 0; i < 99; i++) step();
        chk("to_at99", o_timeout, 0);
        step();
        chk("to_at100", o_timeout, 1);
        step();
        chk("to_hold", o_timeout, 1);
        cyc(0, 0, 1);
        chk("to_pop_clr", o_timeout, 0);
`else
        for (int i = 0; i < 150; i++) step();
        chk("to_disabled", o_timeout, 0);
        cyc(0, 0, 1);
`endif
        chk("final_empty", o_empty, 1);

        for (int i = 0; i < 3; i++) cyc(1, 8'hE0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", o_count, 0);
        chk("async_rst_data", o_rd_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

16-entry receive FIFO sitting directly downstream of `uart_rx`, modelled on the 16550 RX FIFO. Captures each byte presented on `uart_rx`'s `o_data` when its `o_flag` pulses and buffers it for the host/register block. The FIFO provides show-ahead read data, occupancy, a 16550-style trigger-level indication, a sticky overrun flag and an optional character-timeout indication.

## Interface
- `DATA_W`, 8: byte width; matches `uart_rx` `o_data`.
- `TIMEOUT_CYCLES`, 208320: idle cycles before timeout; default is 4 chars × 10 bits × 5208 clk (9600 bd at 50 MHz).
- `i_sys_clk` in 1: system clock; all logic on its rising edge.
- `i_sys_rst_n` in 1: reset, asynchronous, active-low.
- `i_data` in DATA_W: received byte; connect to `uart_rx` `o_data`.
- `i_flag` in 1: one-cycle push strobe; connect to `uart_rx` `o_flag`.
- `i_rd_en` in 1: pop head entry this cycle.
- `i_fifo_clr` in 1: synchronous flush.
- `i_ovr_clr` in 1: clears `o_overrun`.
- `i_trig_lvl` in 2: trigger level; 00=1, 01=4, 10=8, 11=14 entries.
- `o_rd_data` out DATA_W: head entry (show-ahead); valid while `o_empty`=0.
- `o_empty` out 1: count == 0.
- `o_full` out 1: count == 16.
- `o_count` out 5: occupancy, 0..16.
- `o_trig` out 1: count ≥ selected trigger level.
- `o_overrun` out 1: sticky; byte lost.
- `o_timeout` out 1: character timeout (see Configuration).

## Operation
- Storage: 16 × DATA_W register array; 4-bit `wr_ptr`, `rd_ptr` wrap 15→0; 5-bit `count`.
- Push: `i_flag`=1 and (count<16 or pop this cycle) → write `i_data` at `wr_ptr`, `wr_ptr`+1.
- Pop: `i_rd_en`=1 and count>0 → `rd_ptr`+1. Pop while empty ignored; no pointer/count change.
- Count: +1 push only, −1 pop only, unchanged on both or neither.
- Full with push and pop same cycle: both performed, count stays 16, no overrun.
- Empty with push and pop same cycle: push performed, pop ignored, count → 1.
- Overrun: `i_flag`=1, count==16, no pop → byte discarded, FIFO contents unchanged, `o_overrun` set next cycle. Stays set until `i_ovr_clr`; set takes priority over clear in the same cycle.
- Flush: `i_fifo_clr`=1 → pointers and count to 0, overriding any push/pop that cycle. `o_overrun` not affected.
- `o_trig` is combinational from `count` and `i_trig_lvl`; retargets immediately when `i_trig_lvl` changes.

## Timing
- Reset values: pointers and count 0, array 0, `o_rd_data`=0, `o_empty`=1, `o_full`=0, `o_count`=0, `o_trig`=0, `o_overrun`=0, `o_timeout`=0.
- Push latency: byte pushed at edge N appears on `o_rd_data` after edge N, with `o_empty`=0 if the FIFO was empty. Status outputs update at that same edge.
- `o_rd_data` is a combinational read of `mem[rd_ptr]`. After a pop at edge N, the next entry is presented after edge N.
- Reset asserted mid-operation discards all contents immediately, asynchronously.

## Configuration
- `UART_RX_FIFO_TIMEOUT_EN` defined:
  - A 20-bit idle counter runs while count>0 with no push and no pop.
  - It clears on any push, pop, flush, or count==0.
  - `o_timeout` is set at the edge where the counter reaches `TIMEOUT_CYCLES`. It holds until the next push, pop or flush, or until count==0.
- Not defined: counter absent, `o_timeout` tied 0.

## Test plan
- **Single byte.** Reset, push 0x5A → next cycle `o_empty`=0, `o_count`=1, `o_rd_data`=0x5A. Pop → `o_empty`=1.
- **Fill, overrun and wrap.** Push 0x00..0x0F → `o_full`=1. Push 0xAA → `o_overrun`=1, count 16, head still 0x00. Pop all → 0x00..0x0F in order. Push 0x10..0x13 → pointers wrap, data read back correctly.
- **Full push+pop.** Full FIFO, push 0x77 with pop same cycle → `o_overrun`=0, count 16, tail entry 0x77.
- **Trigger levels.** `i_trig_lvl`=10: `o_trig` rises after the 8th push and falls after the pop back to 7. Switch to 11 with count 8 → `o_trig`=0 immediately.
- **Flush.** Flush with 5 entries and `o_overrun`=1 → count 0, `o_empty`=1, `o_overrun` still 1. `i_ovr_clr` → 0.
- **Timeout (macro defined).** With `TIMEOUT_CYCLES`=100, push 1 byte then idle → `o_timeout`=1 exactly 100 cycles later. Pop → `o_timeout`=0.
